// File: rtl/rom_download_writer.sv
// Packs the HPS ioctl download byte stream little-endian into 32-bit SDRAM write
// requests (req/ack). It flushes partial words, stalls the HPS and reports completion.
module rom_download_writer #(
  parameter int unsigned IOCTL_ADDR_WIDTH = 20,
  parameter int unsigned SDRAM_ADDR_WIDTH = 23,
  parameter int unsigned SDRAM_DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [IOCTL_ADDR_WIDTH-1:0] ioctl_addr,
  input  logic [7:0]                  ioctl_data,
  input  logic                        ioctl_wr,
  input  logic                        ioctl_download,
  output logic                        ioctl_wait,
  output logic [SDRAM_ADDR_WIDTH-1:0] sdram_addr,
  output logic [SDRAM_DATA_WIDTH-1:0] sdram_data,
  output logic                        sdram_we,
  output logic                        sdram_req,
  input  logic                        sdram_ack,
  output logic                        done,
  output logic                        overrun,
  output logic [17:0]                 words_written
);

  localparam int unsigned WADDR_W = IOCTL_ADDR_WIDTH - 2;
  localparam int unsigned LANES   = SDRAM_DATA_WIDTH / 8;
  localparam int unsigned WW_W    = 18;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

  state_t                        r_state;
  logic [SDRAM_DATA_WIDTH-1:0]   r_asm_data;
  logic [WADDR_W-1:0]            r_asm_waddr;
  logic [LANES-1:0]              r_asm_mask;
  logic [7:0]                    r_hold_byte;
  logic [IOCTL_ADDR_WIDTH-1:0]   r_hold_addr;
  logic                          r_hold_valid;
  logic                          r_dl_prev;
  logic                          r_end_pending;
  logic                          r_req;
  logic                          r_we;
  logic [SDRAM_ADDR_WIDTH-1:0]   r_sdram_addr;
  logic [SDRAM_DATA_WIDTH-1:0]   r_sdram_data;
  logic                          r_done;
  logic                          r_overrun;
  logic [WW_W-1:0]               r_words;

  logic                          w_dl_rise;
  logic                          w_dl_fall;
  logic [LANES-1:0]              w_mask_eff;
  logic                          w_hold_eff;
  logic                          w_end_eff;
  logic                          w_busy;
  logic                          w_byte_ok;
  logic                          w_overrun_set;
  logic [1:0]                    w_lane;
  logic [1:0]                    w_hold_lane;
  logic [WADDR_W-1:0]            w_waddr;
  logic [SDRAM_DATA_WIDTH-1:0]   w_next_data;
  logic [WADDR_W-1:0]            w_next_waddr;
  logic [LANES-1:0]              w_next_mask;
  logic [LANES-1:0]              w_merge_mask;
  logic                          w_flush;
  logic [SDRAM_DATA_WIDTH-1:0]   w_flush_data;
  logic [WADDR_W-1:0]            w_flush_waddr;
  logic                          w_hold_set;
  logic                          w_hold_clr;
  logic                          w_done_set;
  logic                          w_write_ack;
  logic [WW_W-1:0]               w_words_base;

  // Zero the byte lanes that never received data.
  function automatic logic [SDRAM_DATA_WIDTH-1:0] f_pad(
    input logic [SDRAM_DATA_WIDTH-1:0] d,
    input logic [LANES-1:0]            m
  );
    logic [SDRAM_DATA_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (m[i]) v[8*i +: 8] = d[8*i +: 8];
    end
    return v;
  endfunction

  // A download start discards any assembly/hold state left over from before.
  assign w_dl_rise     = ioctl_download & ~r_dl_prev;
  assign w_dl_fall     = ~ioctl_download & r_dl_prev;
  assign w_mask_eff    = w_dl_rise ? '0 : r_asm_mask;
  assign w_hold_eff    = r_hold_valid & ~w_dl_rise;
  assign w_end_eff     = ~w_dl_rise & (r_end_pending | w_dl_fall);
  assign w_busy        = (r_state == S_WRITE) | w_hold_eff;
  assign w_byte_ok     = ioctl_wr & ioctl_download & ~w_busy;
  assign w_overrun_set = ioctl_wr & ioctl_download & w_busy;
  assign w_lane        = ioctl_addr[1:0];
  assign w_hold_lane   = r_hold_addr[1:0];
  assign w_waddr       = ioctl_addr[IOCTL_ADDR_WIDTH-1:2];
  assign w_write_ack   = (r_state == S_WRITE) & sdram_ack;
  assign w_words_base  = w_dl_rise ? '0 : r_words;

  // Next assembly contents and the flush/hold/done decision for this cycle.
  always_comb begin
    w_next_data   = r_asm_data;
    w_next_waddr  = r_asm_waddr;
    w_next_mask   = w_mask_eff;
    w_merge_mask  = w_mask_eff;
    w_flush       = 1'b0;
    w_flush_data  = f_pad(r_asm_data, w_mask_eff);
    w_flush_waddr = r_asm_waddr;
    w_hold_set    = 1'b0;
    w_hold_clr    = 1'b0;
    w_done_set    = 1'b0;
    if (r_state == S_IDLE) begin
      if (w_hold_eff) begin
        w_hold_clr   = 1'b1;
        w_next_waddr = r_hold_addr[IOCTL_ADDR_WIDTH-1:2];
        w_next_data[8*int'(w_hold_lane) +: 8] = r_hold_byte;
        w_merge_mask = LANES'(1) << w_hold_lane;
        w_next_mask  = w_merge_mask;
        if (w_hold_lane == 2'd3) begin
          w_flush       = 1'b1;
          w_flush_data  = f_pad(w_next_data, w_merge_mask);
          w_flush_waddr = w_next_waddr;
          w_next_mask   = '0;
        end
      end else if (w_byte_ok) begin
        if ((w_mask_eff != '0) && (w_waddr != r_asm_waddr)) begin
          w_flush     = 1'b1;
          w_hold_set  = 1'b1;
          w_next_mask = '0;
        end else begin
          w_next_waddr = w_waddr;
          w_next_data[8*int'(w_lane) +: 8] = ioctl_data;
          w_merge_mask = w_mask_eff | (LANES'(1) << w_lane);
          w_next_mask  = w_merge_mask;
          if (w_lane == 2'd3) begin
            w_flush       = 1'b1;
            w_flush_data  = f_pad(w_next_data, w_merge_mask);
            w_flush_waddr = w_waddr;
            w_next_mask   = '0;
          end
        end
      end else if (w_end_eff) begin
        if (w_mask_eff != '0) begin
          w_flush     = 1'b1;
          w_next_mask = '0;
        end else begin
          w_done_set = 1'b1;
        end
      end
    end else begin
      if (sdram_ack && w_end_eff && !w_hold_eff) w_done_set = 1'b1;
    end
  end

  assign ioctl_wait = (r_state == S_WRITE) | w_flush | w_hold_eff;

  // Request FSM, assembly registers and status counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_asm_data    <= '0;
      r_asm_waddr   <= '0;
      r_asm_mask    <= '0;
      r_hold_byte   <= '0;
      r_hold_addr   <= '0;
      r_hold_valid  <= 1'b0;
      r_dl_prev     <= 1'b0;
      r_end_pending <= 1'b0;
      r_req         <= 1'b0;
      r_we          <= 1'b0;
      r_sdram_addr  <= '0;
      r_sdram_data  <= '0;
      r_done        <= 1'b0;
      r_overrun     <= 1'b0;
      r_words       <= '0;
    end else begin
      r_dl_prev     <= ioctl_download;
      r_done        <= w_done_set;
      r_end_pending <= w_done_set ? 1'b0 : w_end_eff;
      r_asm_data    <= w_next_data;
      r_asm_waddr   <= w_next_waddr;
      r_asm_mask    <= w_next_mask;
      r_overrun     <= w_overrun_set | (r_overrun & ~w_dl_rise);
      r_words       <= w_words_base + WW_W'(w_write_ack);
      if (w_hold_set) begin
        r_hold_byte  <= ioctl_data;
        r_hold_addr  <= ioctl_addr;
        r_hold_valid <= 1'b1;
      end else begin
        r_hold_valid <= w_hold_eff & ~w_hold_clr;
      end
      case (r_state)
        S_IDLE: begin
          if (w_flush) begin
            r_state      <= S_WRITE;
            r_req        <= 1'b1;
            r_we         <= 1'b1;
            r_sdram_addr <= SDRAM_ADDR_WIDTH'({w_flush_waddr, 1'b0});
            r_sdram_data <= w_flush_data;
          end
        end
        S_WRITE: begin
          if (sdram_ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sdram_req     = r_req;
  assign sdram_we      = r_we;
  assign sdram_addr    = r_sdram_addr;
  assign sdram_data    = r_sdram_data;
  assign done          = r_done;
  assign overrun       = r_overrun;
  assign words_written = r_words;

endmodule

// File: tb/tb_rom_download_writer.sv
// Directed bench for rom_download_writer: a latency-programmable SDRAM responder
// logs every write; per-scenario tasks compare against hand-computed values.
module tb_rom_download_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        ioctl_download;
  logic        ioctl_wait;
  logic [22:0] sdram_addr;
  logic [31:0] sdram_data;
  logic        sdram_we;
  logic        sdram_req;
  logic        sdram_ack;
  logic        done;
  logic        overrun;
  logic [17:0] words_written;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat      = 1;
  int req_cnt  = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int ack_cyc  = -1;
  int fall_cyc = -1;
  int wait_viol = 0;
  int we_viol   = 0;
  logic [22:0] q_addr[$];
  logic [31:0] q_data[$];
  int          q_len[$];

  rom_download_writer dut (
    .clk(clk), .reset(reset),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .ioctl_download(ioctl_download), .ioctl_wait(ioctl_wait),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .done(done), .overrun(overrun), .words_written(words_written)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // SDRAM responder: ack in the lat-th cycle of each request, log the write.
  always @(negedge clk) begin
    if (sdram_req === 1'b1) begin
      req_cnt++;
      if (ioctl_wait !== 1'b1) wait_viol++;
      if (req_cnt >= lat && sdram_ack !== 1'b1) begin
        sdram_ack = 1'b1;
        ack_cyc   = cyc;
        q_addr.push_back(sdram_addr);
        q_data.push_back(sdram_data);
        q_len.push_back(req_cnt);
      end
    end else begin
      req_cnt   = 0;
      sdram_ack = 1'b0;
    end
    if (sdram_we !== sdram_req) we_viol++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic start_dl();
    q_addr.delete(); q_data.delete(); q_len.delete();
    done_cnt = 0; wait_viol = 0; we_viol = 0;
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [19:0] a, input logic [7:0] d);
    int g = 0;
    while (ioctl_wait === 1'b1 && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) begin
      checks++; failures++;
      $display("FAIL send_timeout addr=%0h got wait=1 exp wait=0", a);
    end
    ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((sdram_req === 1'b1 || ioctl_wait === 1'b1) && g < 300) begin @(negedge clk); g++; end
    if (g >= 300) begin
      checks++; failures++;
      $display("FAIL idle_timeout got req=%0b wait=%0b exp 0", sdram_req, ioctl_wait);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic end_dl();
    int g = 0;
    int d0 = done_cnt;
    ioctl_download = 1'b0;
    fall_cyc = cyc;
    while (done_cnt == d0 && g < 300) begin @(negedge clk); g++; end
    if (g >= 300) begin
      checks++; failures++;
      $display("FAIL done_timeout got done_cnt=%0d exp >%0d", done_cnt, d0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; ioctl_wr = 1'b0; ioctl_download = 1'b0;
    ioctl_addr = '0; ioctl_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", sdram_req); end
    checks++; if (sdram_addr !== 23'h0) begin failures++; $display("FAIL rst_addr got=%0h exp=0", sdram_addr); end
    checks++; if (sdram_data !== 32'h0) begin failures++; $display("FAIL rst_data got=%0h exp=0", sdram_data); end
    checks++; if ({ioctl_wait, done, overrun} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {ioctl_wait, done, overrun}); end
    checks++; if (words_written !== 18'h0) begin failures++; $display("FAIL rst_words got=%0d exp=0", words_written); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_word();
    lat = 1;
    start_dl();
    send_byte(20'h0, 8'h11); send_byte(20'h1, 8'h22);
    send_byte(20'h2, 8'h33); send_byte(20'h3, 8'h44);
    wait_idle();
    checks++; if (q_addr.size() !== 1) begin failures++; $display("FAIL fw_count got=%0d exp=1", q_addr.size()); end
    else begin
      checks++; if (q_addr[0] !== 23'h0) begin failures++; $display("FAIL fw_addr got=%0h exp=0", q_addr[0]); end
      checks++; if (q_data[0] !== 32'h44332211) begin failures++; $display("FAIL fw_data got=%0h exp=44332211", q_data[0]); end
      checks++; if (q_len[0] !== 1) begin failures++; $display("FAIL fw_len got=%0d exp=1", q_len[0]); end
    end
    checks++; if (words_written !== 18'd1) begin failures++; $display("FAIL fw_words got=%0d exp=1", words_written); end
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL fw_early_done got=%0d exp=0", done_cnt); end
    end_dl();
    checks++; if (done_cyc !== fall_cyc + 1) begin failures++; $display("FAIL fw_done_cyc got=%0d exp=%0d", done_cyc, fall_cyc + 1); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL fw_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_slow_ack();
    lat = 5;
    start_dl();
    for (int i = 0; i < 8; i++) send_byte(20'h100 + 20'(i), 8'(i + 1));
    wait_idle();
    checks++; if (q_addr.size() !== 2) begin failures++; $display("FAIL sa_count got=%0d exp=2", q_addr.size()); end
    else begin
      checks++; if (q_addr[0] !== 23'h80 || q_addr[1] !== 23'h82) begin failures++; $display("FAIL sa_addr got=%0h,%0h exp=80,82", q_addr[0], q_addr[1]); end
      checks++; if (q_data[0] !== 32'h04030201 || q_data[1] !== 32'h08070605) begin failures++; $display("FAIL sa_data got=%0h,%0h exp=04030201,08070605", q_data[0], q_data[1]); end
      checks++; if (q_len[0] !== 5 || q_len[1] !== 5) begin failures++; $display("FAIL sa_len got=%0d,%0d exp=5,5", q_len[0], q_len[1]); end
    end
    checks++; if (wait_viol !== 0) begin failures++; $display("FAIL sa_wait got=%0d low cycles exp=0", wait_viol); end
    checks++; if (we_viol !== 0) begin failures++; $display("FAIL sa_we got=%0d mismatched cycles exp=0", we_viol); end
    checks++; if (words_written !== 18'd2) begin failures++; $display("FAIL sa_words got=%0d exp=2", words_written); end
    end_dl();
    lat = 1;
  endtask

  task automatic test_partial_flush();
    lat = 2;
    start_dl();
    send_byte(20'h10, 8'hAA); send_byte(20'h11, 8'hBB); send_byte(20'h12, 8'hCC);
    repeat (2) @(negedge clk);
    checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL pf_no_req got=%0b exp=0", sdram_req); end
    end_dl();
    checks++; if (q_addr.size() !== 1) begin failures++; $display("FAIL pf_count got=%0d exp=1", q_addr.size()); end
    else begin
      checks++; if (q_addr[0] !== 23'h08) begin failures++; $display("FAIL pf_addr got=%0h exp=8", q_addr[0]); end
      checks++; if (q_data[0] !== 32'h00CCBBAA) begin failures++; $display("FAIL pf_data got=%0h exp=00ccbbaa", q_data[0]); end
    end
    checks++; if (done_cyc !== ack_cyc + 1) begin failures++; $display("FAIL pf_done_cyc got=%0d exp=%0d", done_cyc, ack_cyc + 1); end
    checks++; if (words_written !== 18'd1) begin failures++; $display("FAIL pf_words got=%0d exp=1", words_written); end
    lat = 1;
  endtask

  task automatic test_hold();
    lat = 3;
    start_dl();
    send_byte(20'h4, 8'h55);
    send_byte(20'h20, 8'h66);
    wait_idle();
    checks++; if (q_addr.size() !== 1) begin failures++; $display("FAIL hd_first_count got=%0d exp=1", q_addr.size()); end
    end_dl();
    checks++; if (q_addr.size() !== 2) begin failures++; $display("FAIL hd_count got=%0d exp=2", q_addr.size()); end
    else begin
      checks++; if (q_addr[0] !== 23'h02 || q_data[0] !== 32'h00000055) begin failures++; $display("FAIL hd_w0 got=%0h/%0h exp=2/55", q_addr[0], q_data[0]); end
      checks++; if (q_addr[1] !== 23'h10 || q_data[1] !== 32'h00000066) begin failures++; $display("FAIL hd_w1 got=%0h/%0h exp=10/66", q_addr[1], q_data[1]); end
    end
    checks++; if (words_written !== 18'd2) begin failures++; $display("FAIL hd_words got=%0d exp=2", words_written); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL hd_done_cnt got=%0d exp=1", done_cnt); end
    lat = 1;
  endtask

  task automatic test_overrun();
    lat = 5;
    start_dl();
    send_byte(20'h0, 8'h10); send_byte(20'h1, 8'h20);
    send_byte(20'h2, 8'h30); send_byte(20'h3, 8'h40);
    @(negedge clk);
    checks++; if (sdram_req !== 1'b1) begin failures++; $display("FAIL ov_req_pending got=%0b exp=1", sdram_req); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ov_pre got=%0b exp=0", overrun); end
    ioctl_addr = 20'h4; ioctl_data = 8'h99; ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ov_set got=%0b exp=1", overrun); end
    wait_idle();
    end_dl();
    checks++; if (q_addr.size() !== 1) begin failures++; $display("FAIL ov_count got=%0d exp=1", q_addr.size()); end
    else begin
      checks++; if (q_data[0] !== 32'h40302010) begin failures++; $display("FAIL ov_data got=%0h exp=40302010", q_data[0]); end
    end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ov_sticky got=%0b exp=1", overrun); end
    start_dl();
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ov_clear got=%0b exp=0", overrun); end
    checks++; if (words_written !== 18'd0) begin failures++; $display("FAIL ov_words_clear got=%0d exp=0", words_written); end
    end_dl();
    lat = 1;
  endtask

  task automatic test_reset_mid_write();
    int d0;
    lat = 50;
    start_dl();
    send_byte(20'h8, 8'h01); send_byte(20'h9, 8'h02);
    send_byte(20'hA, 8'h03); send_byte(20'hB, 8'h04);
    repeat (2) @(negedge clk);
    checks++; if (sdram_req !== 1'b1) begin failures++; $display("FAIL rw_req_before got=%0b exp=1", sdram_req); end
    reset = 1'b1; ioctl_download = 1'b0;
    @(negedge clk);
    checks++; if (sdram_req !== 1'b0 || sdram_we !== 1'b0) begin failures++; $display("FAIL rw_req_after got=%0b/%0b exp=0/0", sdram_req, sdram_we); end
    checks++; if (words_written !== 18'd0) begin failures++; $display("FAIL rw_words got=%0d exp=0", words_written); end
    reset = 1'b0;
    d0 = done_cnt;
    repeat (6) @(negedge clk);
    checks++; if (done_cnt !== d0 || done !== 1'b0) begin failures++; $display("FAIL rw_no_done got=%0d exp=%0d", done_cnt, d0); end
    checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL rw_req_stays_low got=%0b exp=0", sdram_req); end
    lat = 1;
  endtask

  initial begin
    sdram_ack = 1'b0;
    test_reset();
    test_full_word();
    test_slow_ack();
    test_partial_flush();
    test_hold();
    test_overrun();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
